// File: rtl/wb_arbiter_if.sv
// Signal bundle between two Wishbone masters, the arbiter and one shared slave.
// The arbiter takes the master modport (it masters the shared bus); the surrounding system takes slave.
interface wb_arbiter_if;
  logic        m0_cyc_i, m1_cyc_i;
  logic        m0_stb_i, m1_stb_i;
  logic        m0_we_i,  m1_we_i;
  logic [29:0] m0_adr_i, m1_adr_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_i, m1_dat_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_err_o, m1_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [29:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    input  m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    input  m0_adr_i, m1_adr_i, m0_sel_i, m1_sel_i, m0_dat_i, m1_dat_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    output m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    output m0_adr_i, m1_adr_i, m0_sel_i, m1_sel_i, m0_dat_i, m1_dat_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with a one-cycle turnaround between owners.
// Optional stalled-strobe timeout abort is built when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  wb_arbiter_if.master  bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state_q, state_d;
  logic   rr_q, rr_d;
  logic   gnt, own1, timeout;

  logic        m_cyc, m_stb, m_we;
  logic [29:0] m_adr;
  logic [3:0]  m_sel;
  logic [31:0] m_dat;

  assign gnt  = (state_q != IDLE);
  assign own1 = (state_q == GRANT1);

  // Owner mux: everything the slave sees comes from the granted master.
  assign m_cyc = own1 ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign m_stb = own1 ? bus.m1_stb_i : bus.m0_stb_i;
  assign m_we  = own1 ? bus.m1_we_i  : bus.m0_we_i;
  assign m_adr = own1 ? bus.m1_adr_i : bus.m0_adr_i;
  assign m_sel = own1 ? bus.m1_sel_i : bus.m0_sel_i;
  assign m_dat = own1 ? bus.m1_dat_i : bus.m0_dat_i;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) state_d = rr_q ? GRANT1 : GRANT0;
        else if (bus.m0_cyc_i)            state_d = GRANT0;
        else if (bus.m1_cyc_i)            state_d = GRANT1;
      end
      GRANT0: if (!bus.m0_cyc_i) begin
        state_d = IDLE;
        rr_d    = 1'b1;
      end
      GRANT1: if (!bus.m1_cyc_i) begin
        state_d = IDLE;
        rr_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       stalled;

  // A strobe waiting on the slave; the raw master strobe is used, not the forced-low copy.
  assign stalled = gnt && m_stb && !bus.ack_i;
  assign timeout = stalled && (cnt_q == CntLast);

  always_comb begin
    cnt_d = 8'd0;
    if (stalled && !timeout && (state_d == state_q)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    bus.cyc_o    = 1'b0;
    bus.stb_o    = 1'b0;
    bus.we_o     = 1'b0;
    bus.adr_o    = '0;
    bus.sel_o    = '0;
    bus.dat_o    = '0;
    bus.m0_ack_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m0_dat_o = '0;
    bus.m1_dat_o = '0;
    if (gnt) begin
      bus.cyc_o = m_cyc;
      bus.stb_o = m_stb && !timeout;
      bus.we_o  = m_we;
      bus.adr_o = m_adr;
      bus.sel_o = m_sel;
      bus.dat_o = m_dat;
      if (own1) begin
        bus.m1_ack_o = bus.ack_i;
        bus.m1_dat_o = bus.dat_i;
        bus.m1_err_o = timeout;
      end else begin
        bus.m0_ack_o = bus.ack_i;
        bus.m0_dat_o = bus.dat_i;
        bus.m0_err_o = timeout;
      end
    end
  end

endmodule
